// File: rtl/mul_job_sequencer.sv
// Job sequencer for the repeated-addition multiplier: queues operand pairs, runs one
// multiply at a time with a timeout guard, and holds each result on a valid/ready port.
module mul_job_sequencer #(
    parameter int W       = 16,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 1024
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_a,
    input  logic [W-1:0] in_b,
    output logic [W-1:0] mul_Ain,
    output logic [W-1:0] mul_Bin,
    output logic         mul_start,
    input  logic         mul_done,
    input  logic [W-1:0] mul_P,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_p,
    output logic         out_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(TIMEOUT) + 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RELEASE} state_t;

    state_t          state;
    logic [W-1:0]    mem_a [DEPTH];
    logic [W-1:0]    mem_b [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW:0]     count;
    logic [CW-1:0]   tcnt;
    logic            push;
    logic            pop;

    // in_ready looks only at the registered occupancy, so a same-cycle pop never frees a slot
    assign in_ready = (count != (AW+1)'(DEPTH));
    assign push     = in_valid && in_ready;
    assign pop      = (state == IDLE) && (count != '0) && !out_valid;

    always_ff @(posedge clk) begin
        if (push) begin
            mem_a[wr_ptr] <= in_a;
            mem_b[wr_ptr] <= in_b;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // tcnt counts cycles since start rose: zero in ISSUE, so a hung job ends TIMEOUT cycles after start
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            mul_start <= 1'b0;
            mul_Ain   <= '0;
            mul_Bin   <= '0;
            tcnt      <= '0;
            out_valid <= 1'b0;
            out_p     <= '0;
            out_err   <= 1'b0;
        end else begin
            if (out_valid && out_ready) out_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (pop) begin
                        mul_Ain   <= mem_a[rd_ptr];
                        mul_Bin   <= mem_b[rd_ptr];
                        mul_start <= 1'b1;
                        tcnt      <= '0;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    tcnt  <= tcnt + CW'(1);
                    state <= WAIT;
                end
                WAIT: begin
                    tcnt <= tcnt + CW'(1);
                    if (mul_done) begin
                        out_p     <= mul_P;
                        out_err   <= 1'b0;
                        out_valid <= 1'b1;
                        mul_start <= 1'b0;
                        state     <= RELEASE;
                    end else if (tcnt == CW'(TIMEOUT - 1)) begin
                        out_p     <= '0;
                        out_err   <= 1'b1;
                        out_valid <= 1'b1;
                        mul_start <= 1'b0;
                        state     <= RELEASE;
                    end
                end
                RELEASE: begin
                    // the multiplier must drop done before another job may start
                    if (!mul_done) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_job_sequencer.sv
// Bench for mul_job_sequencer with a behavioural repeated-addition multiplier that can be
// forced to hang for timeout checks.
module tb_mul_job_sequencer;

    localparam int W       = 16;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic [W-1:0] mul_Ain;
    logic [W-1:0] mul_Bin;
    logic         mul_start;
    logic         mul_done;
    logic [W-1:0] mul_P;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_p;
    logic         out_err;

    int n_chk  = 0;
    int n_fail = 0;

    mul_job_sequencer #(.W(W), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .mul_Ain(mul_Ain), .mul_Bin(mul_Bin), .mul_start(mul_start),
        .mul_done(mul_done), .mul_P(mul_P),
        .out_valid(out_valid), .out_ready(out_ready), .out_p(out_p), .out_err(out_err)
    );

    always #5 clk = ~clk;

    // Repeated-addition multiplier: load on start, add A B times, hold done until start drops
    logic         stub_hang = 1'b0;
    logic [1:0]   mst;
    logic [W-1:0] mcnt;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mst   <= 2'd0;
            mul_P <= '0;
            mcnt  <= '0;
        end else begin
            case (mst)
                2'd0: if (mul_start) begin
                    mul_P <= '0;
                    mcnt  <= mul_Bin;
                    mst   <= 2'd1;
                end
                2'd1: if (mcnt == '0) mst <= 2'd2;
                      else begin
                          mul_P <= mul_P + mul_Ain;
                          mcnt  <= mcnt - 1'b1;
                      end
                default: if (!mul_start) mst <= 2'd0;
            endcase
        end
    end
    assign mul_done = (mst == 2'd2) && !stub_hang;

    // Count start rising edges and operand changes while start is held
    int           starts   = 0;
    int           unstable = 0;
    logic         prev_start = 1'b0;
    logic [W-1:0] pa, pb;
    always @(posedge clk) begin
        if (mul_start && !prev_start) starts++;
        if (mul_start && prev_start && (mul_Ain != pa || mul_Bin != pb)) unstable++;
        prev_start = mul_start;
        pa = mul_Ain;
        pb = mul_Bin;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [W-1:0] a, input logic [W-1:0] b, output bit acc);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        acc      = in_ready;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic get_result(input string name, output logic [W-1:0] p, output logic e);
        bit got = 0;
        p = '0;
        e = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 80 && !got; i++) begin
            if (out_valid) begin
                p   = out_p;
                e   = out_err;
                got = 1;
            end
            tick();
        end
        out_ready = 1'b0;
        chk({name, "_arrived"}, got, 1);
        chk({name, "_valid_dropped"}, out_valid, 0);
    endtask

    task automatic wait_valid(input string name);
        bit got = 0;
        for (int i = 0; i < 80 && !got; i++) begin
            if (out_valid) got = 1;
            else tick();
        end
        chk({name, "_held"}, got, 1);
    endtask

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] p;
        logic         err;
    } vec_t;

    vec_t         vt [6];
    logic [W-1:0] rp;
    logic         re;
    bit           acc;
    int           s0;
    int           k;

    initial begin
        vt[0] = '{a: 16'd17,    b: 16'd5, p: 16'd85,    err: 1'b0};
        vt[1] = '{a: 16'd9,     b: 16'd0, p: 16'd0,     err: 1'b0};
        vt[2] = '{a: 16'd0,     b: 16'd7, p: 16'd0,     err: 1'b0};
        vt[3] = '{a: 16'd3,     b: 16'd4, p: 16'd12,    err: 1'b0};
        vt[4] = '{a: 16'd40000, b: 16'd3, p: 16'd54464, err: 1'b0};
        vt[5] = '{a: 16'd65535, b: 16'd2, p: 16'd65534, err: 1'b0};

        rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b0;
        tick();
        tick();
        chk("rst_in_ready", in_ready, 1);
        chk("rst_mul_start", mul_start, 0);
        chk("rst_mul_Ain", mul_Ain, 0);
        chk("rst_mul_Bin", mul_Bin, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_p", out_p, 0);
        chk("rst_out_err", out_err, 0);
        rst = 1'b0;
        tick();

        foreach (vt[i]) begin
            s0 = starts;
            push(vt[i].a, vt[i].b, acc);
            chk($sformatf("vec%0d_accepted", i), acc, 1);
            get_result($sformatf("vec%0d", i), rp, re);
            chk($sformatf("vec%0d_p", i), rp, vt[i].p);
            chk($sformatf("vec%0d_err", i), re, vt[i].err);
            chk($sformatf("vec%0d_Ain", i), mul_Ain, vt[i].a);
            chk($sformatf("vec%0d_Bin", i), mul_Bin, vt[i].b);
            chk($sformatf("vec%0d_one_start", i), starts - s0, 1);
        end

        // Timeout: multiplier never answers
        stub_hang = 1'b1;
        push(16'd5, 16'd5, acc);
        for (int i = 0; i < 10 && !mul_start; i++) tick();
        chk("to_start_seen", mul_start, 1);
        k = 0;
        while (!out_valid && k < 40) begin
            tick();
            k++;
        end
        chk("to_latency", k, 16);
        get_result("to", rp, re);
        chk("to_p", rp, 0);
        chk("to_err", re, 1);
        stub_hang = 1'b0;
        tick();

        // Backpressure: hold one result, fill the FIFO, then drain in order
        push(16'd11, 16'd2, acc);
        wait_valid("bp_first");
        push(16'd2, 16'd3, acc); chk("bp_acc1", acc, 1);
        push(16'd4, 16'd5, acc); chk("bp_acc2", acc, 1);
        push(16'd6, 16'd1, acc); chk("bp_acc3", acc, 1);
        push(16'd7, 16'd7, acc); chk("bp_acc4", acc, 1);
        push(16'd8, 16'd8, acc); chk("bp_acc5_refused", acc, 0);
        s0 = starts;
        for (int i = 0; i < 10; i++) tick();
        chk("bp_no_start", starts - s0, 0);
        chk("bp_start_low", mul_start, 0);
        get_result("bp0", rp, re); chk("bp0_p", rp, 22);
        get_result("bp1", rp, re); chk("bp1_p", rp, 6);
        get_result("bp2", rp, re); chk("bp2_p", rp, 20);
        get_result("bp3", rp, re); chk("bp3_p", rp, 6);
        get_result("bp4", rp, re); chk("bp4_p", rp, 49);
        for (int i = 0; i < 20; i++) tick();
        chk("bp_empty", dut.count, 0);
        chk("bp_no_extra", out_valid, 0);

        // Push lands on the pop edge with one entry queued
        push(16'd12, 16'd3, acc);
        wait_valid("sp_first");
        push(16'd5, 16'd6, acc);
        tick();
        chk("sp_held_p", out_p, 36);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("sp_released", out_valid, 0);
        push(16'd3, 16'd9, acc);
        chk("sp_push_acc", acc, 1);
        chk("sp_count_kept", dut.count, 1);
        chk("sp_start", mul_start, 1);
        chk("sp_Ain", mul_Ain, 5);
        get_result("sp1", rp, re); chk("sp1_p", rp, 30);
        get_result("sp2", rp, re); chk("sp2_p", rp, 27);

        // Reset while in WAIT with two pairs queued
        stub_hang = 1'b1;
        push(16'd13, 16'd2, acc);
        push(16'd14, 16'd3, acc);
        push(16'd15, 16'd4, acc);
        tick();
        chk("rw_in_job", mul_start, 1);
        chk("rw_queued", dut.count, 2);
        #2 rst = 1'b1;
        #1;
        chk("rw_start_low", mul_start, 0);
        chk("rw_in_ready", in_ready, 1);
        chk("rw_out_valid", out_valid, 0);
        chk("rw_flushed", dut.count, 0);
        tick();
        rst = 1'b0;
        stub_hang = 1'b0;
        tick();
        s0 = starts;
        push(16'd6, 16'd7, acc);
        get_result("rw", rp, re);
        chk("rw_p", rp, 42);
        chk("rw_err", re, 0);
        chk("rw_Ain", mul_Ain, 6);
        for (int i = 0; i < 30; i++) tick();
        chk("rw_no_stale", out_valid, 0);
        chk("rw_one_start", starts - s0, 1);

        chk("operands_stable", unstable, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got 0, expected 1");
        $fatal(1);
    end

endmodule
